// File: rtl/accel_led_meter.sv
// ============================================================================
// accel_led_meter : block-averaged LED bar/dot meter with a decaying peak marker
// Rev 1.0
// ============================================================================
`default_nettype none

module accel_led_meter #(
   parameter int WIDTH      = 9,
   parameter int NUM_LEDS   = 16,
   parameter int AVG_LOG    = 2,
   parameter int ZERO_BLANK = 2,
   parameter int PEAK_HOLD  = 50_000_000,
   parameter int PEAK_DECAY = 5_000_000,
   localparam int LW        = $clog2(NUM_LEDS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [WIDTH-1:0]    sample,
   input  logic                sample_valid,
   input  logic                mode,
   output logic [LW-1:0]       level,
   output logic                blank,
   output logic                level_valid,
   output logic [LW-1:0]       peak,
   output logic [NUM_LEDS-1:0] led
);

   localparam int ACW = WIDTH + AVG_LOG;
   localparam int CW  = (AVG_LOG > 0) ? AVG_LOG : 1;
   localparam int HW  = $clog2(PEAK_HOLD + 1);
   localparam int DW  = $clog2(PEAK_DECAY + 1);

   localparam logic [CW-1:0] C_CNT_LAST    = CW'((1 << AVG_LOG) - 1);
   localparam logic [HW-1:0] C_HOLD_LOAD   = HW'(PEAK_HOLD - 1);
   localparam logic [DW-1:0] C_DECAY_LOAD  = DW'(PEAK_DECAY - 1);
   localparam logic [31:0]   C_ZERO_BLANK  = 32'(ZERO_BLANK);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_HOLD  = 2'd1;
   localparam logic [1:0] S_DECAY = 2'd2;

   // ------------------------------------------------------------------------
   // Block averaging and quantisation
   // ------------------------------------------------------------------------
   logic [ACW-1:0]   r_acc;
   logic [CW-1:0]    r_cnt;
   logic [ACW-1:0]   w_sum;
   logic [WIDTH-1:0] w_avg;
   logic [LW-1:0]    w_quant;
   logic             w_last;

   // The sum of a full block of WIDTH-bit samples always fits in ACW bits.
   assign w_sum  = r_acc + ACW'(sample);
   assign w_avg  = WIDTH'(w_sum >> AVG_LOG);
   assign w_last = (r_cnt == C_CNT_LAST);

   // (avg * NUM_LEDS) >> WIDTH is just the top LW bits of avg.
   generate
      if (WIDTH >= LW) begin : g_quant_shift
         assign w_quant = w_avg[WIDTH-1 -: LW];
      end else begin : g_quant_pad
         assign w_quant = {w_avg, {(LW-WIDTH){1'b0}}};
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         level       <= '0;
         blank       <= 1'b1;
         level_valid <= 1'b0;
      end else begin
         level_valid <= 1'b0;
         if (sample_valid) begin
            if (w_last) begin
               r_acc       <= '0;
               r_cnt       <= '0;
               level       <= w_quant;
               blank       <= (32'(w_avg) < C_ZERO_BLANK);
               level_valid <= 1'b1;
            end else begin
               r_acc <= w_sum;
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Peak tracker
   // ------------------------------------------------------------------------
   logic [1:0]          r_state;
   logic [1:0]          w_state_nxt;
   logic [HW-1:0]       r_hold;
   logic [HW-1:0]       w_hold_nxt;
   logic [DW-1:0]       r_decay;
   logic [DW-1:0]       w_decay_nxt;
   logic [LW-1:0]       w_peak_nxt;
   logic [LW-1:0]       w_eff;
   logic                w_rise;
   logic [NUM_LEDS-1:0] w_led_nxt;

   assign w_eff  = blank ? '0 : level;
   assign w_rise = level_valid && (w_eff > peak);

   // led is registered from the next peak so it shows the new marker together
   // with the peak register, one clock after level updates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_hold  <= '0;
         r_decay <= '0;
         peak    <= '0;
         led     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_hold  <= w_hold_nxt;
         r_decay <= w_decay_nxt;
         peak    <= w_peak_nxt;
         led     <= w_led_nxt;
      end
   end

   // A new higher level always beats a hold or decay expiry in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_decay_nxt = r_decay;
      w_peak_nxt  = peak;
      case (r_state)
         S_IDLE: begin
            if (level_valid && !blank) begin
               w_peak_nxt  = level;
               w_hold_nxt  = C_HOLD_LOAD;
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (w_rise) begin
               w_peak_nxt = level;
               w_hold_nxt = C_HOLD_LOAD;
            end else if (r_hold == '0) begin
               w_decay_nxt = C_DECAY_LOAD;
               w_state_nxt = S_DECAY;
            end else begin
               w_hold_nxt = r_hold - 1'b1;
            end
         end
         S_DECAY: begin
            if (w_rise) begin
               w_peak_nxt  = level;
               w_hold_nxt  = C_HOLD_LOAD;
               w_state_nxt = S_HOLD;
            end else if (r_decay == '0) begin
               w_decay_nxt = C_DECAY_LOAD;
               if (peak > w_eff) begin
                  w_peak_nxt = peak - 1'b1;
               end else if (blank) begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_decay_nxt = r_decay - 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      w_led_nxt = '0;
      if (!blank) begin
         for (int i = 0; i < NUM_LEDS; i++) begin
            if (mode ? (LW'(i) <= level) : (LW'(i) == level)) begin
               w_led_nxt[i] = 1'b1;
            end
         end
      end
      if (w_state_nxt != S_IDLE) begin
         w_led_nxt[w_peak_nxt] = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_accel_led_meter.sv
// ============================================================================
// tb_accel_led_meter : scoreboard bench with a behavioural meter reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_accel_led_meter;

   localparam int WIDTH      = 9;
   localparam int NUM_LEDS   = 16;
   localparam int LW         = 4;
   localparam int AVG_LOG    = 2;
   localparam int ZERO_BLANK = 2;
   localparam int PEAK_HOLD  = 10;
   localparam int PEAK_DECAY = 4;
   localparam int BLK        = 1 << AVG_LOG;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic [WIDTH-1:0]    sample = '0;
   logic                sample_valid = 1'b0;
   logic                mode = 1'b0;
   logic [LW-1:0]       level;
   logic                blank;
   logic                level_valid;
   logic [LW-1:0]       peak;
   logic [NUM_LEDS-1:0] led;

   int checks   = 0;
   int failures = 0;

   accel_led_meter #(
      .WIDTH      (WIDTH),
      .NUM_LEDS   (NUM_LEDS),
      .AVG_LOG    (AVG_LOG),
      .ZERO_BLANK (ZERO_BLANK),
      .PEAK_HOLD  (PEAK_HOLD),
      .PEAK_DECAY (PEAK_DECAY)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample       (sample),
      .sample_valid (sample_valid),
      .mode         (mode),
      .level        (level),
      .blank        (blank),
      .level_valid  (level_valid),
      .peak         (peak),
      .led          (led)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: blocks of samples -> average -> level; peak marker
   // timed by absolute clock-edge deadlines rather than down-counters.
   // ------------------------------------------------------------------------
   typedef enum int {M_IDLE, M_HOLD, M_DECAY} mstate_t;

   mstate_t             m_st = M_IDLE;
   int                  m_level = 0;
   int                  m_blank = 1;
   int                  m_lv = 0;
   int                  m_peak = 0;
   int                  eff;
   int                  sum;
   int                  avg;
   logic [NUM_LEDS-1:0] m_led = '0;
   longint              ecnt = 0;
   longint              t_hold_end = 0;
   longint              t_step = 0;
   int                  blk_q[$];
   int                  sb_q[$];
   int                  sb_item;

   always @(posedge clk) begin
      ecnt++;
      if (reset) begin
         blk_q.delete();
         sb_q.delete();
         m_level = 0;
         m_blank = 1;
         m_lv    = 0;
         m_peak  = 0;
         m_st    = M_IDLE;
         m_led   = '0;
      end else begin
         eff = m_blank ? 0 : m_level;
         case (m_st)
            M_IDLE: begin
               if (m_lv && !m_blank) begin
                  m_peak = m_level;
                  m_st = M_HOLD;
                  t_hold_end = ecnt + PEAK_HOLD;
               end
            end
            M_HOLD: begin
               if (m_lv && eff > m_peak) begin
                  m_peak = m_level;
                  t_hold_end = ecnt + PEAK_HOLD;
               end else if (ecnt == t_hold_end) begin
                  m_st = M_DECAY;
                  t_step = ecnt + PEAK_DECAY;
               end
            end
            default: begin
               if (m_lv && eff > m_peak) begin
                  m_peak = m_level;
                  m_st = M_HOLD;
                  t_hold_end = ecnt + PEAK_HOLD;
               end else if (ecnt == t_step) begin
                  t_step = ecnt + PEAK_DECAY;
                  if (m_peak > eff) m_peak--;
                  else if (m_blank) m_st = M_IDLE;
               end
            end
         endcase

         m_led = '0;
         for (int i = 0; i < NUM_LEDS; i++) begin
            if (!m_blank && (mode ? (i <= m_level) : (i == m_level))) m_led[i] = 1'b1;
         end
         if (m_st != M_IDLE) m_led[m_peak] = 1'b1;

         m_lv = 0;
         if (sample_valid) begin
            blk_q.push_back(int'(sample));
            if (blk_q.size() == BLK) begin
               sum = 0;
               foreach (blk_q[j]) sum += blk_q[j];
               avg = sum / BLK;
               m_level = (avg * NUM_LEDS) / (1 << WIDTH);
               m_blank = (avg < ZERO_BLANK) ? 1 : 0;
               m_lv = 1;
               sb_q.push_back(m_level * 2 + m_blank);
               blk_q.delete();
            end
         end
      end
   end

   // Monitor: per-cycle display check plus scoreboard pop on each level_valid.
   always @(negedge clk) begin
      if (!reset) begin
         chk("led", 32'(led), 32'(m_led));
         chk("peak", 32'(peak), m_peak);
         chk("level_valid", 32'(level_valid), m_lv);
         if (level_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected: got level_valid=1 expected no pending average");
            end else begin
               sb_item = sb_q.pop_front();
               chk("sb_level", 32'(level), sb_item / 2);
               chk("sb_blank", 32'(blank), sb_item % 2);
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   task automatic send(input int s);
      sample = WIDTH'(s);
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic send4(input int a, input int b, input int c, input int d);
      send(a);
      send(b);
      send(c);
      send(d);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sample_valid = 1'b0;
      idle(2);
      reset = 1'b0;
   endtask

   initial begin
      idle(2);
      reset = 1'b0;
      chk("rst_level", 32'(level), 0);
      chk("rst_blank", 32'(blank), 1);
      chk("rst_level_valid", 32'(level_valid), 0);
      chk("rst_peak", 32'(peak), 0);
      chk("rst_led", 32'(led), 0);

      // Full scale, dot mode, then hold/decay down to a lower level and blank.
      mode = 1'b0;
      send4(511, 511, 511, 511);
      chk("fs_level_valid", 32'(level_valid), 1);
      chk("fs_level", 32'(level), 15);
      chk("fs_blank", 32'(blank), 0);
      idle(1);
      chk("fs_led", 32'(led), 32'h8000);
      chk("fs_peak", 32'(peak), 15);
      send4(100, 100, 100, 100);
      idle(1);
      chk("hold_led", 32'(led), 32'h8008);
      idle(70);
      chk("decay_merged_led", 32'(led), 32'h0008);
      send4(0, 0, 0, 0);
      idle(30);
      chk("decay_idle_led", 32'(led), 0);
      chk("decay_idle_peak", 32'(peak), 0);

      // Averaging in bar mode, then mode toggles without new samples.
      do_reset();
      mode = 1'b1;
      send4(0, 0, 256, 256);
      chk("bar_level", 32'(level), 4);
      chk("bar_blank", 32'(blank), 0);
      idle(1);
      chk("bar_led", 32'(led), 32'h001F);
      chk("bar_peak", 32'(peak), 4);
      mode = 1'b0;
      idle(1);
      chk("toggle_dot_led", 32'(led), 32'h0010);
      mode = 1'b1;
      idle(1);
      chk("toggle_bar_led", 32'(led), 32'h001F);

      // Blank average stays idle.
      do_reset();
      mode = 1'b0;
      send4(0, 1, 1, 1);
      chk("blank_blank", 32'(blank), 1);
      chk("blank_level", 32'(level), 0);
      idle(1);
      chk("blank_led", 32'(led), 0);
      idle(5);
      chk("blank_led_later", 32'(led), 0);

      // Reset mid-block discards the partial sum.
      do_reset();
      send(511);
      send(511);
      do_reset();
      send4(64, 64, 64, 64);
      chk("midrst_level_valid", 32'(level_valid), 1);
      chk("midrst_level", 32'(level), 2);

      // Higher level lands on the same edge as hold expiry.
      do_reset();
      mode = 1'b0;
      send4(128, 128, 128, 128);
      idle(PEAK_HOLD - 4);
      send4(511, 511, 511, 511);
      chk("coinc_level", 32'(level), 15);
      idle(1);
      chk("coinc_peak", 32'(peak), 15);
      idle(PEAK_HOLD - 1);
      chk("coinc_hold_peak", 32'(peak), 15);

      // Randomised traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 599) == 0) do_reset();
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         if ($urandom_range(0, 99) == 0) begin
            sample_valid = 1'b0;
            idle(40);
         end
         if ($urandom_range(0, 3) != 0) begin
            if ($urandom_range(0, 9) < 3) sample = WIDTH'($urandom_range(0, 3));
            else sample = WIDTH'($urandom_range(0, 511));
            sample_valid = 1'b1;
         end else begin
            sample_valid = 1'b0;
         end
         @(negedge clk);
      end
      sample_valid = 1'b0;
      idle(10);
      chk("sb_drained", 32'(sb_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/accel_led_meter.md
# accel_led_meter

Parametrised LED bar/dot meter for accelerometer axis readings. It block-averages a stream of unsigned samples, quantises the average into one of NUM_LEDS levels, and drives the LED bank in dot or bar mode. A peak-hold marker decays over time. It sits between the accelerometer interface (axis output plus a sample strobe) and the board LED pins. It replaces the fixed 16-LED combinational threshold ladder.

## Interface
Parameters:
- WIDTH, 9: sample width in bits (unsigned).
- NUM_LEDS, 16: LED count; power of two, 2..32. LW = log2(NUM_LEDS).
- AVG_LOG, 2: average over 2^AVG_LOG samples; range 0..4.
- ZERO_BLANK, 2: averages below this value blank the level display.
- PEAK_HOLD, 50_000_000: clocks the peak marker holds before decaying; ≥1.
- PEAK_DECAY, 5_000_000: clocks per one-level decay step; ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample  in  WIDTH  axis reading, for example accelY.
- sample_valid  in  1  one-cycle strobe; sample is accepted when high.
- mode  in  1  0 = dot (one-hot level), 1 = bar (thermometer 0..level).
- level  out  LW  current quantised level.
- blank  out  1  the current average is below ZERO_BLANK.
- level_valid  out  1  one-cycle pulse when level and blank update.
- peak  out  LW  current peak-marker level.
- led  out  NUM_LEDS  LED drive.

## Operation
- **Accumulator.** Width is WIDTH+AVG_LOG. The sample counter is AVG_LOG bits wide. Each accepted sample is added to the accumulator and increments the counter.
- **End of block.** On the 2^AVG_LOG-th sample, avg = (acc + sample) >> AVG_LOG, floor and exact. The accumulator and counter then clear.
- **Quantisation.** level = (avg × NUM_LEDS) >> WIDTH, floored; the range is 0..NUM_LEDS−1. blank = (avg < ZERO_BLANK).
- **Peak tracker.** It has states IDLE, HOLD and DECAY. The effective level is 0 when blank.
  - IDLE: peak_active = 0. On level_valid with blank = 0, set peak = level, load the hold counter, and go to HOLD.
  - HOLD: on level_valid with effective level > peak, set peak = level and reload the hold counter. When the counter expires, go to DECAY with the decay counter loaded.
  - DECAY: on level_valid with effective level > peak, set peak = level and go to HOLD. Otherwise, each PEAK_DECAY clocks:
    - if peak > effective level, peak decrements;
    - if peak == effective level and blank = 1, go to IDLE;
    - if peak == effective level and blank = 0, peak stays (it tracks the level).
  - peak_active is 1 in HOLD and DECAY.
- **LED composition.**
  - Level bits in dot mode: led[level].
  - Level bits in bar mode: led[0..level].
  - Level bits are 0 when blank = 1.
  - Then OR in led[peak] if peak_active.
- **Mode change.** A change of mode affects led on the next clock without needing a new sample.

## Timing
- Reset values (async assert, sync release): accumulator 0, counter 0, level 0, blank 1, level_valid 0, peak 0, state IDLE, led all 0.
- Completing sample accepted at cycle t: level, blank and level_valid = 1 at t+1. level_valid is low at t+2 unless re-triggered.
- Peak and state update at t+2. led reflects the new level and peak at t+2.
- Back-to-back sample_valid every cycle is supported with no sample dropped. With AVG_LOG = 0, every sample produces level_valid.
- Hold counter: the marker holds for exactly PEAK_HOLD clocks after its last load, then enters DECAY. The first decrement occurs PEAK_DECAY clocks later.
- A level_valid arriving in the same cycle as a hold or decay counter expiry takes priority: the peak update and reload win.
- Reset mid-block discards the partial accumulation.
- Intermediate arithmetic has no overflow. The accumulator never wraps for WIDTH-bit inputs.

## Test plan
- **Full-scale, dot mode.** WIDTH=9, NUM_LEDS=16, AVG_LOG=2, mode=0; four samples of 9'h1FF. Expect level=15, blank=0, level_valid one pulse, led=16'h8000.
- **Averaging and bar mode.** Samples 0, 0, 9'h100, 9'h100 (avg 9'h080), mode=1. Expect level=4 and led=16'h001F, with the peak marker coinciding at bit 4.
- **Blank after reset.** Samples 0, 1, 1, 1 (avg 0). Expect blank=1, led=16'h0000, state stays IDLE.
- **Peak hold and decay.** Use PEAK_HOLD=10, PEAK_DECAY=4, mode=0. Drive level 15, then level 3.
  - Expect led=16'h8008 for 10 clocks after the peak load.
  - Then the marker drops one bit every 4 clocks until it merges at bit 3 (led=16'h0008).
  - Repeat with blank samples: expect the marker to reach bit 0, return to IDLE, and led=0.
- **Reset mid-block.** Send two samples of 9'h1FF, assert reset, then send four samples of 9'h040. Expect the first level_valid to give level=2 (earlier samples discarded).
- **Mode toggle and simultaneous events.** Toggle mode with no samples: led switches between 16'h0010 and 16'h001F on the next clock. Separately, force level_valid with a higher level on the same cycle as hold-counter expiry: expect the peak to update and stay in HOLD.
